// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and baud divisor helper.
// Defining UART_TX_PARITY_EN adds the PARITY state (8E1 frames).
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    // Clock cycles per bit, truncated; callers must keep the result >= 2.
    function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_baud.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled and flags the last cycle of each bit.
module uart_tx_baud #(
    parameter int BAUD_DIV = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic bit_tick
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign bit_tick = en && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined); one byte per accepted request.
// Handshake: a request is accepted on the edge where tx_start=1 and tx_busy=0; tx_done pulses as busy falls.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       rs232_tx,
    output logic [2:0] dbg_state
);

    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_tx;
`ifdef UART_TX_PARITY_EN
    logic       r_parity;
`endif

    logic w_accept;
    logic w_bit_tick;

    assign w_accept = tx_start & ~r_busy;

    uart_tx_baud #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_accept),
        .en       (r_busy),
        .bit_tick (w_bit_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_START;
                        r_shift   <= tx_data;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_tx      <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= ^tx_data;
`endif
                    end
                end
                ST_START: begin
                    if (w_bit_tick) begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                ST_DATA: begin
                    if (w_bit_tick) begin
                        // Counter wraps back to 0 after the last data bit, ready for the stop phase.
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_tx <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_tick) begin
                        r_state   <= ST_STOP;
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_tick) begin
                        if (r_bit_cnt == LAST_STOP) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_busy   = r_busy;
    assign tx_done   = r_done;
    assign rs232_tx  = r_tx;
    assign dbg_state = r_state;

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serializes one byte per request onto `rs232_tx` as an 8N1 frame: start bit, 8 data bits LSB first, stop bit. It is the transmit counterpart of the logic-analyser UART receive path and drives the same RS-232 line level (idle high). Unlike the receive path, it has its own internal baud divider, so it needs no external `clk_bps`/`bps_start` pair.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s. `BAUD_DIV = CLK_FREQ / BAUD_RATE`, integer, truncated (5208 at default). `BAUD_DIV` must be ≥ 2.
- `clk`  in  1  system clock (50 MHz). Only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tx_data`  in  8  byte to send; sampled only on the accepting edge.
- `tx_start`  in  1  request; level-sampled.
- `tx_busy`  out  1  high from the accepting edge until the frame ends.
- `tx_done`  out  1  one-cycle pulse at frame end.
- `rs232_tx`  out  1  serial line, registered.

## Operation
- FSM states and transitions:
  - IDLE → START when `tx_start & ~tx_busy`.
  - START → DATA after `BAUD_DIV` cycles.
  - DATA → STOP after 8 bits.
  - DATA → PARITY → STOP when parity is compiled in.
  - STOP → IDLE after `BAUD_DIV` cycles.
- Accepting edge:
  - Latches `tx_data` into the shift register.
  - Clears the baud counter and bit counter.
  - Sets `tx_busy=1` and `rs232_tx=0` on that same edge.
- Baud counter: counts 0..`BAUD_DIV`-1. `bit_tick` is asserted at `BAUD_DIV`-1; the counter wraps to 0 and the next bit is driven.
- Bit counter: 3 bits, 0..7. DATA exits when `bit_tick` occurs with count = 7.
- Data bits: `rs232_tx` = shift register bit 0; the register shifts right on each `bit_tick` in DATA.
- Requests while `tx_busy=1` are ignored. `tx_data` changes mid-frame have no effect.
- Reset values: `rs232_tx=1`, `tx_busy=0`, `tx_done=0`, state IDLE, counters 0.
- Reset asserted mid-frame: the frame is aborted. On the next edge `rs232_tx=1` and `tx_busy=0`, and no `tx_done` is produced.

## Timing
- Let E0 be the accepting edge and `D` = `BAUD_DIV`.
- Start bit is driven from E0 through E0+D-1.
- Data bit k (k = 0..7) is driven from E0+(k+1)·D for D cycles.
- Stop bit (high) is driven from E0+9·D through E0+10·D-1.
- At edge E0+10·D:
  - `tx_done=1` for exactly one cycle.
  - `tx_busy=0`.
  - `rs232_tx` stays 1.
- Back-to-back: a request held during the `tx_done` cycle is accepted at E0+10·D+1. The effective stop bit is therefore D+1 cycles, and the inter-frame gap is 1 clock minimum.
- With parity compiled in, every post-data boundary shifts by D. `tx_done` is then at E0+11·D.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - An even-parity bit (XOR of the 8 latched data bits) is sent for D cycles between data bit 7 and the stop bit.
  - The frame becomes 8E1, 11·D cycles long.
- Undefined: 8N1 frame of 10·D cycles, and the PARITY state does not exist.

## Structure
- Shared package `uart_pkg` holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - the `BAUD_DIV` computation function;
  - frame constants `DATA_BITS=8` and `STOP_BITS=1`.
- Sub-module `uart_tx_baud`:
  - Parameterized by `BAUD_DIV`.
  - Inputs: `clk`, `rst_n`, `clr` (synchronous clear, asserted at acceptance), `en` (high while busy).
  - Output: `bit_tick`.
  - The FSM, shift register and bit counter stay in `uart_tx`.

## Test plan
All scenarios run with `CLK_FREQ=1_000_000` and `BAUD_RATE=100_000` (D = 10), checking `rs232_tx` every cycle against a reference frame model.
- **Reset:** hold `rst_n=0` for 3 cycles with `tx_start=1` → `rs232_tx=1`, `tx_busy=0`, `tx_done=0` throughout; no frame starts before release.
- **Single frame:** send `tx_data=0xA5` → line shows 0 for 10 cycles, then 1,0,1,0,0,1,0,1 each for 10 cycles, then 1 for 10 cycles. `tx_done` pulses once at E0+100, the same edge `tx_busy` falls.
- **Request while busy:** pulse `tx_start` with `tx_data=0x3C` at E0+40 during the 0xA5 frame → frame unchanged, exactly one `tx_done`, no second frame.
- **Back-to-back:** send 0x00, then hold `tx_start` high with 0xFF → second start bit falls at E0+101. Line carries all-zero data, then all-one data. Two `tx_done` pulses 101 cycles apart.
- **Reset mid-frame:** assert `rst_n=0` during data bit 3 → `rs232_tx=1` and `tx_busy=0` one edge later; no `tx_done`. After release, a new 0x55 frame is sent correctly.
- **Parity:**
  - With `UART_TX_PARITY_EN`, send 0x07 → parity bit 1 at E0+90..E0+99, stop bit at E0+100..E0+109, `tx_done` at E0+110.
  - Without the macro, the same byte gives `tx_done` at E0+100.
